vidtiming: RTL and testbench
============================

// Module: vidtiming
// PURPOSE
//   Raster timing generator for the video subsystem; runs on the 2x pixel clock (two clocks per pixel).
//   Produces htiming, vtiming_f and cmpblk for the tile generator and sprite engine, sync to the DAC,
//   and the vblank NMI request to the Z80. Sits upstream of tilegen.
// PARAMETERS
//   H_JUMP      10'h300  hcount reload after 10'h1FF (start of hblank); line = 512 + 256 = 768 clocks
//   HSYNC_START 10'h340  first hcount with hsync_n low
//   HSYNC_END   10'h3A0  first hcount with hsync_n high again
//   V_FIRST     9'h0F8   vcount reload after 9'h1FF; frame = 264 lines
//   VACT_START  9'h110   first active line
//   VACT_END    9'h1F0   first vblank line (NMI edge)
//   VSYNC_END   9'h100   vsync_n low while V_FIRST <= vcount < VSYNC_END
// PORTS
//   clk         in   1   2x pixel clock
//   rst_n       in   1   asynchronous reset, active low
//   flip_ena    in   1   screen flip request from vidctrl register
//   nmi_ena     in   1   vblank NMI enable from vidctrl; 0 clears the request
//   htiming     out  10  horizontal count; bit 9 = 1 in hblank
//   vtiming     out  9   raw vertical count
//   vtiming_f   out  8   vtiming[7:0] XOR {8{flip_lat}}
//   flip_lat    out  1   frame-latched flip, fed to tilegen flip_ena
//   hblk, vblk  out  1   horizontal / vertical blank
//   cmpblk      out  1   hblk | vblk
//   hsync_n     out  1   horizontal sync, active low
//   vsync_n     out  1   vertical sync, active low
//   nmi_n       out  1   vblank NMI to CPU, active low, level-held
//   frame_stb   out  1   one-clock pulse on first clock of VACT_END line
// BEHAVIOUR
//   Reset (async, rst_n = 0):
//     hcount = H_JUMP; vcount = V_FIRST; flip_lat = 0.
//     hblk = vblk = cmpblk = 1; hsync_n = 1; vsync_n = 0; nmi_n = 1; frame_stb = 0.
//   Counting:
//     Every clock, hcount += 1, except 10'h1FF -> H_JUMP and 10'h3FF -> 10'h000 (line end).
//     vcount advances only on the line-end clock: +1, except 9'h1FF -> V_FIRST.
//   Output timing:
//     All outputs are registers, decoded from next-state counts, so they change on the same edge as the counters.
//     No output lags the counters.
//     hblk = htiming[9]; vblk = (vcount < VACT_START) | (vcount >= VACT_END).
//     hsync_n low for HSYNC_START <= hcount < HSYNC_END.
//   Flip:
//     flip_ena is sampled into flip_lat only on the line-end clock that enters VACT_END (start of vblank).
//     Mid-frame changes have no effect until the next vblank.
//   NMI:
//     On entry to line VACT_END (line-end clock), nmi_n <= 0 if nmi_ena = 1.
//     nmi_ena = 0 forces nmi_n <= 1 on the next clock; this has priority over a set in the same clock.
//     nmi_n stays low until cleared; it does not self-clear.
//   frame_stb: high exactly one clock, the clock where vcount becomes VACT_END and hcount becomes 0.
//   Simultaneous line-end and frame wrap (hcount 3FF, vcount 1FF):
//     both counters reload on the same edge; vblk stays 1; vsync_n falls.
//   Reset mid-line: counters and outputs return to reset values immediately; counting resumes on the first edge after release.
//   Widths: counters are unsigned and wrap only at the stated reload points; no other values are reachable.
// STRUCTURE
//   Constants H_JUMP ... VSYNC_END and a vid_timing_t struct {htiming, vtiming_f, cmpblk, flip} go in video_pkg.
//   vid_timing_t is shared with tilegen and the sprite engine.
//   Single module, no sub-modules: two counters plus output decode registers.
// TESTING
//   Release reset, run 768 clocks -> hcount sequence 300..3FF,000..1FF; one line-end; vcount 0F8 -> 0F9.
//   Run a full frame (202752 clocks) -> back to hcount=300, vcount=0F8; exactly 1 frame_stb.
//     Within that frame: 224 lines with vblk = 0; 768 - 512 = 256 hblk clocks per line.
//   flip_ena=1 asserted at vcount=0x150 -> vtiming_f unflipped until vcount=1F0; at vcount=1F0, vtiming_f = 8'h0F.
//   nmi_ena=1 -> nmi_n falls with frame_stb, stays low; nmi_ena=0 -> nmi_n=1 next clock.
//     nmi_ena held 0 through vblank -> nmi_n never falls.
//   Sync widths: hsync_n low 0x60 = 96 clocks per line; vsync_n low 8 lines (0F8..0FF) per frame.
//   Assert rst_n=0 asynchronously at hcount=0x123 -> outputs at reset values before the next edge;
//     after release, the count resumes from hcount 300.

Source files
------------

// File: rtl/video_pkg.sv
// Raster constants and the timing bundle shared by vidtiming, tilegen and the sprite engine.
// Counts run on the 2x pixel clock: 768 clocks per line, 264 lines per frame.
package video_pkg;

   localparam logic [9:0] H_JUMP      = 10'h300;
   localparam logic [9:0] HSYNC_START = 10'h340;
   localparam logic [9:0] HSYNC_END   = 10'h3A0;
   localparam logic [8:0] V_FIRST     = 9'h0F8;
   localparam logic [8:0] VACT_START  = 9'h110;
   localparam logic [8:0] VACT_END    = 9'h1F0;
   localparam logic [8:0] VSYNC_END   = 9'h100;

   typedef struct packed {
      logic [9:0] htiming;
      logic [7:0] vtiming_f;
      logic       cmpblk;
      logic       flip;
   } vid_timing_t;

   // Half-open window tests [lo, hi) used by the sync and active-area decodes.
   function automatic logic in_hwin(input logic [9:0] val, input logic [9:0] lo, input logic [9:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

   function automatic logic in_vwin(input logic [8:0] val, input logic [8:0] lo, input logic [8:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/vidtiming_if.sv
// Timing bus between the raster generator (master) and its consumers / vidctrl (slave).
interface vidtiming_if;
   import video_pkg::*;

   logic        flip_ena;
   logic        nmi_ena;
   logic [9:0]  htiming;
   logic [8:0]  vtiming;
   logic [7:0]  vtiming_f;
   logic        flip_lat;
   logic        hblk;
   logic        vblk;
   logic        cmpblk;
   logic        hsync_n;
   logic        vsync_n;
   logic        nmi_n;
   logic        frame_stb;
   vid_timing_t timing;

   modport master (
      input  flip_ena, nmi_ena,
      output htiming, vtiming, vtiming_f, flip_lat, hblk, vblk, cmpblk,
             hsync_n, vsync_n, nmi_n, frame_stb, timing
   );

   modport slave (
      output flip_ena, nmi_ena,
      input  htiming, vtiming, vtiming_f, flip_lat, hblk, vblk, cmpblk,
             hsync_n, vsync_n, nmi_n, frame_stb, timing
   );

endinterface

// File: rtl/vidtiming.sv
// Raster timing generator: horizontal/vertical counters plus output decode registers.
// Every output is decoded from the next-state counts so it changes on the same edge as the counters.
module vidtiming
   import video_pkg::*;
#(
   parameter logic [9:0] P_H_JUMP      = H_JUMP,
   parameter logic [9:0] P_HSYNC_START = HSYNC_START,
   parameter logic [9:0] P_HSYNC_END   = HSYNC_END,
   parameter logic [8:0] P_V_FIRST     = V_FIRST,
   parameter logic [8:0] P_VACT_START  = VACT_START,
   parameter logic [8:0] P_VACT_END    = VACT_END,
   parameter logic [8:0] P_VSYNC_END   = VSYNC_END
) (
   input  logic        clk,
   input  logic        rst_n,
   vidtiming_if.master vt
);

   logic [9:0] hcount_q, hcount_d;
   logic [8:0] vcount_q, vcount_d;
   logic [7:0] vtiming_f_q, vtiming_f_d;
   logic       flip_q, flip_d;
   logic       nmi_n_q, nmi_n_d;
   logic       hblk_q, hblk_d;
   logic       vblk_q, vblk_d;
   logic       cmpblk_q;
   logic       hsync_n_q, hsync_n_d;
   logic       vsync_n_q, vsync_n_d;
   logic       frame_stb_q;
   logic       line_end;
   logic       enter_vblank;

   always_comb begin
      line_end = (hcount_q == 10'h3FF);

      // 3FF + 1 wraps naturally to 000; only the jump into hblank needs a reload.
      if (hcount_q == 10'h1FF) begin
         hcount_d = P_H_JUMP;
      end else begin
         hcount_d = hcount_q + 10'd1;
      end

      vcount_d = vcount_q;
      if (line_end) begin
         if (vcount_q == 9'h1FF) begin
            vcount_d = P_V_FIRST;
         end else begin
            vcount_d = vcount_q + 9'd1;
         end
      end

      enter_vblank = line_end && (vcount_d == P_VACT_END);

      flip_d = enter_vblank ? vt.flip_ena : flip_q;

      // A disable wins over a set arriving on the same clock.
      if (!vt.nmi_ena) begin
         nmi_n_d = 1'b1;
      end else if (enter_vblank) begin
         nmi_n_d = 1'b0;
      end else begin
         nmi_n_d = nmi_n_q;
      end

      vtiming_f_d = vcount_d[7:0] ^ {8{flip_d}};
      hblk_d      = hcount_d[9];
      vblk_d      = !in_vwin(vcount_d, P_VACT_START, P_VACT_END);
      hsync_n_d   = !in_hwin(hcount_d, P_HSYNC_START, P_HSYNC_END);
      vsync_n_d   = !in_vwin(vcount_d, P_V_FIRST, P_VSYNC_END);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcount_q    <= P_H_JUMP;
         vcount_q    <= P_V_FIRST;
         vtiming_f_q <= P_V_FIRST[7:0];
         flip_q      <= 1'b0;
         nmi_n_q     <= 1'b1;
         hblk_q      <= 1'b1;
         vblk_q      <= 1'b1;
         cmpblk_q    <= 1'b1;
         hsync_n_q   <= 1'b1;
         vsync_n_q   <= 1'b0;
         frame_stb_q <= 1'b0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         vtiming_f_q <= vtiming_f_d;
         flip_q      <= flip_d;
         nmi_n_q     <= nmi_n_d;
         hblk_q      <= hblk_d;
         vblk_q      <= vblk_d;
         cmpblk_q    <= hblk_d | vblk_d;
         hsync_n_q   <= hsync_n_d;
         vsync_n_q   <= vsync_n_d;
         frame_stb_q <= enter_vblank;
      end
   end

   assign vt.htiming   = hcount_q;
   assign vt.vtiming   = vcount_q;
   assign vt.vtiming_f = vtiming_f_q;
   assign vt.flip_lat  = flip_q;
   assign vt.hblk      = hblk_q;
   assign vt.vblk      = vblk_q;
   assign vt.cmpblk    = cmpblk_q;
   assign vt.hsync_n   = hsync_n_q;
   assign vt.vsync_n   = vsync_n_q;
   assign vt.nmi_n     = nmi_n_q;
   assign vt.frame_stb = frame_stb_q;

   always_comb begin
      vt.timing           = '0;
      vt.timing.htiming   = hcount_q;
      vt.timing.vtiming_f = vtiming_f_q;
      vt.timing.cmpblk    = cmpblk_q;
      vt.timing.flip      = flip_q;
   end

endmodule

// File: tb/tb_vidtiming.sv
// Bench for vidtiming: a full-size instance and a short-frame instance run side by side,
// each compared every clock against a scoreboard of expected outputs, plus directed checks.
module tb_vidtiming;
   import video_pkg::*;

   typedef struct packed {
      logic [8:0] vfirst;
      logic [8:0] vsend;
      logic [8:0] vastart;
      logic [8:0] vaend;
   } vparam_t;

   typedef struct packed {
      logic [9:0] h;
      logic [8:0] v;
      logic       flip;
      logic       nmi;
      logic       stb;
   } mstate_t;

   typedef struct packed {
      logic [9:0]  h;
      logic [8:0]  v;
      logic [7:0]  vf;
      logic        flip;
      logic        hblk;
      logic        vblk;
      logic        cmpblk;
      logic        hs;
      logic        vs;
      logic        nmi;
      logic        stb;
      vid_timing_t tm;
   } obs_t;

   // Short frame: 32 lines, vsync 1E0..1E7, active 1E8..1EF, vblank from 1F0.
   localparam logic [8:0] S_V_FIRST    = 9'h1E0;
   localparam logic [8:0] S_VSYNC_END  = 9'h1E8;
   localparam logic [8:0] S_VACT_START = 9'h1E8;
   localparam logic [8:0] S_VACT_END   = 9'h1F0;
   localparam int         FRAME_S      = 32 * 768;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flip_ena = 1'b0;
   logic nmi_ena = 1'b0;

   always #5 clk = ~clk;

   vidtiming_if vif_d ();
   vidtiming_if vif_s ();

   assign vif_d.flip_ena = flip_ena;
   assign vif_d.nmi_ena  = nmi_ena;
   assign vif_s.flip_ena = flip_ena;
   assign vif_s.nmi_ena  = nmi_ena;

   vidtiming u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vt    (vif_d.master)
   );

   vidtiming #(
      .P_V_FIRST    (S_V_FIRST),
      .P_VACT_START (S_VACT_START),
      .P_VACT_END   (S_VACT_END),
      .P_VSYNC_END  (S_VSYNC_END)
   ) u_short (
      .clk   (clk),
      .rst_n (rst_n),
      .vt    (vif_s.master)
   );

   obs_t obs_d, obs_s;
   assign obs_d = {vif_d.htiming, vif_d.vtiming, vif_d.vtiming_f, vif_d.flip_lat, vif_d.hblk,
                   vif_d.vblk, vif_d.cmpblk, vif_d.hsync_n, vif_d.vsync_n, vif_d.nmi_n,
                   vif_d.frame_stb, vif_d.timing};
   assign obs_s = {vif_s.htiming, vif_s.vtiming, vif_s.vtiming_f, vif_s.flip_lat, vif_s.hblk,
                   vif_s.vblk, vif_s.cmpblk, vif_s.hsync_n, vif_s.vsync_n, vif_s.nmi_n,
                   vif_s.frame_stb, vif_s.timing};

   int checks = 0;
   int errors = 0;
   int tick_no = 0;
   int hblk_cnt = 0;
   int hsync_cnt = 0;
   int stb_cnt = 0;
   int act_cnt = 0;
   int vs_cnt = 0;
   int nmi_cnt = 0;

   vparam_t pd, ps;
   mstate_t md, ms;
   obs_t exp_d[$];
   obs_t exp_s[$];

   function automatic mstate_t reset_state(input vparam_t p);
      mstate_t s;
      s.h    = 10'h300;
      s.v    = p.vfirst;
      s.flip = 1'b0;
      s.nmi  = 1'b1;
      s.stb  = 1'b0;
      return s;
   endfunction

   function automatic mstate_t mstep(input mstate_t s, input vparam_t p, input logic fe, input logic ne);
      mstate_t n;
      logic    wrap;
      wrap = (s.h == 10'h3FF);
      n.h  = (s.h == 10'h1FF) ? 10'h300 : s.h + 10'd1;
      n.v  = s.v;
      if (wrap) n.v = (s.v == 9'h1FF) ? p.vfirst : s.v + 9'd1;
      n.stb  = wrap && (n.v == p.vaend);
      n.flip = n.stb ? fe : s.flip;
      n.nmi  = !ne ? 1'b1 : (n.stb ? 1'b0 : s.nmi);
      return n;
   endfunction

   function automatic obs_t mout(input mstate_t s, input vparam_t p);
      obs_t o;
      o.h            = s.h;
      o.v            = s.v;
      o.vf           = s.v[7:0] ^ {8{s.flip}};
      o.flip         = s.flip;
      o.hblk         = (s.h >= 10'h200);
      o.vblk         = (s.v < p.vastart) || (s.v >= p.vaend);
      o.cmpblk       = o.hblk | o.vblk;
      o.hs           = !((s.h >= 10'h340) && (s.h < 10'h3A0));
      o.vs           = !((s.v >= p.vfirst) && (s.v < p.vsend));
      o.nmi          = s.nmi;
      o.stb          = s.stb;
      o.tm.htiming   = s.h;
      o.tm.vtiming_f = o.vf;
      o.tm.cmpblk    = o.cmpblk;
      o.tm.flip      = s.flip;
      return o;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      obs_t e;
      md = mstep(md, pd, flip_ena, nmi_ena);
      ms = mstep(ms, ps, flip_ena, nmi_ena);
      exp_d.push_back(mout(md, pd));
      exp_s.push_back(mout(ms, ps));
      @(posedge clk);
      #1;
      tick_no++;
      e = exp_d.pop_front();
      check($sformatf("cyc_dflt_%0d", tick_no), 64'(obs_d), 64'(e));
      e = exp_s.pop_front();
      check($sformatf("cyc_short_%0d", tick_no), 64'(obs_s), 64'(e));
      if (tick_no <= 768) begin
         if (vif_d.hblk) hblk_cnt++;
         if (!vif_d.hsync_n) hsync_cnt++;
      end
      if (tick_no <= FRAME_S) begin
         if (vif_s.frame_stb) stb_cnt++;
         if (!vif_s.vblk) act_cnt++;
         if (!vif_s.vsync_n) vs_cnt++;
         if (!vif_s.nmi_n) nmi_cnt++;
      end
   endtask

   task automatic run_until(input logic [8:0] target);
      for (int i = 0; i < 30000 && vif_s.vtiming !== target; i++) tick();
      check($sformatf("reach_v%h", target), 64'(vif_s.vtiming), 64'(target));
   endtask

   initial begin
      logic [9:0] eh;
      pd = '{vfirst: 9'h0F8, vsend: 9'h100, vastart: 9'h110, vaend: 9'h1F0};
      ps = '{vfirst: S_V_FIRST, vsend: S_VSYNC_END, vastart: S_VACT_START, vaend: S_VACT_END};
      md = reset_state(pd);
      ms = reset_state(ps);

      repeat (3) @(posedge clk);
      #1;
      check("reset_dflt", 64'(obs_d), 64'(mout(md, pd)));
      check("reset_short", 64'(obs_s), 64'(mout(ms, ps)));
      $display("step: reset released at h=%h v=%h", vif_d.htiming, vif_d.vtiming);
      rst_n = 1'b1;

      // One line: 301..3FF, 000..1FF, then back to 300 on the next line.
      for (int i = 1; i <= 768; i++) begin
         tick();
         eh = (i < 256) ? 10'(i + 'h300) : ((i < 768) ? 10'(i - 256) : 10'h300);
         check("hseq", 64'(vif_d.htiming), 64'(eh));
      end
      check("line_v", 64'(vif_d.vtiming), 64'(9'h0F9));
      check("hblk_per_line", 64'(hblk_cnt), 64'd256);
      check("hsync_per_line", 64'(hsync_cnt), 64'd96);
      $display("step: one line done, hblk=%0d hsync=%0d", hblk_cnt, hsync_cnt);

      // Frame 1: NMI disabled, flip requested mid-active.
      run_until(9'h1EC);
      flip_ena = 1'b1;
      run_until(9'h1EF);
      check("unflipped_1EF", 64'(vif_s.vtiming_f), 64'(8'hEF));
      check("fliplat_pre", 64'(vif_s.flip_lat), 64'd0);
      run_until(9'h1F0);
      check("flipped_1F0", 64'(vif_s.vtiming_f), 64'(8'h0F));
      check("stb_at_1F0", 64'(vif_s.frame_stb), 64'd1);
      check("fliplat_post", 64'(vif_s.flip_lat), 64'd1);
      for (int i = 0; i < 30000 && tick_no < FRAME_S; i++) tick();
      check("frame_end_h", 64'(vif_s.htiming), 64'(10'h300));
      check("frame_end_v", 64'(vif_s.vtiming), 64'(9'h1E0));
      check("dflt_v_after", 64'(vif_d.vtiming), 64'(9'h118));
      check("stb_per_frame", 64'(stb_cnt), 64'd1);
      check("active_clocks", 64'(act_cnt), 64'(8 * 768));
      check("vsync_clocks", 64'(vs_cnt), 64'(8 * 768));
      check("nmi_held_off", 64'(nmi_cnt), 64'd0);
      $display("step: frame 1 done, stb=%0d act=%0d vs=%0d nmi=%0d", stb_cnt, act_cnt, vs_cnt, nmi_cnt);

      // Frame 2: NMI enabled; flip withdrawn mid-frame takes effect only at vblank.
      nmi_ena = 1'b1;
      run_until(9'h1E2);
      flip_ena = 1'b0;
      run_until(9'h1EC);
      check("still_flipped", 64'(vif_s.vtiming_f), 64'(8'h13));
      run_until(9'h1F0);
      check("nmi_fall", 64'(vif_s.nmi_n), 64'd0);
      check("stb_frame2", 64'(vif_s.frame_stb), 64'd1);
      check("unflip_1F0", 64'(vif_s.vtiming_f), 64'(8'hF0));
      repeat (5) tick();
      check("nmi_held", 64'(vif_s.nmi_n), 64'd0);
      nmi_ena = 1'b0;
      tick();
      check("nmi_clear", 64'(vif_s.nmi_n), 64'd1);
      $display("step: frame 2 vblank, nmi cleared to %b", vif_s.nmi_n);

      // Asynchronous reset in mid-line.
      for (int i = 0; i < 1024 && vif_d.htiming !== 10'h123; i++) tick();
      check("reach_h123", 64'(vif_d.htiming), 64'(10'h123));
      #2;
      rst_n = 1'b0;
      #1;
      md = reset_state(pd);
      ms = reset_state(ps);
      check("async_rst_dflt", 64'(obs_d), 64'(mout(md, pd)));
      check("async_rst_short", 64'(obs_s), 64'(mout(ms, ps)));
      @(posedge clk);
      #1;
      check("rst_hold", 64'(vif_d.htiming), 64'(10'h300));
      rst_n = 1'b1;
      repeat (4) tick();
      check("resume_h", 64'(vif_d.htiming), 64'(10'h304));
      $display("step: async reset, resumed at h=%h", vif_d.htiming);

      check("queue_empty", 64'(exp_d.size() + exp_s.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
